multdiv_seq: RTL and testbench

//  Iterative signed 32-bit multiply/divide sequencer; execute-stage multicycle unit beside the ALU.

---
 rtl/multdiv_pkg.sv | 8 +
 rtl/multdiv_counter.sv | 22 ++
 rtl/multdiv_seq.sv | 164 ++++++++++++++++
 tb/tb_multdiv_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide sequencer.
package multdiv_pkg;
  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_e;
endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: cleared on start, advances while an op runs and holds
// at WIDTH-1 so it never wraps within an operation.
module multdiv_counter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = multdiv_pkg::CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);
  logic [CNT_W-1:0] count;

  assign last = (count == CNT_W'(WIDTH - 1));

  // Count register with clear taking priority over increment.
  always_ff @(posedge clock) begin
    if (reset || clr) count <= '0;
    else if (inc && !last) count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) sequencer.
// Optional feature macro: MULTDIV_EARLY_EXC_EN (divide-by-zero finishes in one cycle).
module multdiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  import multdiv_pkg::*;

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic             start, early_dz, last;
  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic             q1_q, neg_q, dz_q, ovf_q;
  logic [WIDTH-1:0] abs_a, abs_b;

  // Booth step signals
  booth_op_e        op;
  logic [WIDTH:0]   hx, mx, bsum;
  logic [WIDTH-1:0] b_hi, b_lo;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]   ptop;
  logic             mul_exc;

  // Restoring-divide step signals
  logic [WIDTH:0]   rsh, rdiff;
  logic             ge;
  logic [WIDTH-1:0] d_hi, d_lo, quo;

  assign start = ctrl_MULT | ctrl_DIV;
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_EARLY_EXC_EN
  assign early_dz = ctrl_DIV & ~ctrl_MULT & (data_operandB == '0);
`else
  assign early_dz = 1'b0;
`endif

  multdiv_counter #(.WIDTH(WIDTH), .CNT_W(CW)) u_counter (
    .clock (clock),
    .reset (reset),
    .clr   (start),
    .inc   (busy),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and status outputs; a start overrides whatever is in flight.
  always_comb begin
    state_d        = state_q;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state_q)
      MUL, DIV: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        state_d        = IDLE;
      end
      default: ;
    endcase
    if (start) state_d = early_dz ? DONE : (ctrl_MULT ? MUL : DIV);
  end

  // One Booth step; the add is done one bit wider so MIN multiplicands cannot overflow.
  always_comb begin
    op = NOP;
    case ({lo_q[0], q1_q})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
    hx = {hi_q[WIDTH-1], hi_q};
    mx = {m_q[WIDTH-1], m_q};
    case (op)
      ADD:     bsum = hx + mx;
      SUB:     bsum = hx - mx;
      default: bsum = hx;
    endcase
    b_hi    = bsum[WIDTH:1];
    b_lo    = {bsum[0], lo_q[WIDTH-1:1]};
    product = {b_hi, b_lo};
    ptop    = product[2*WIDTH-1:WIDTH-1];
    mul_exc = ~((&ptop) | ~(|ptop));
  end

  // One restoring-divide step on magnitudes, plus final sign fix.
  always_comb begin
    rsh   = {hi_q, lo_q[WIDTH-1]};
    rdiff = rsh - {1'b0, m_q};
    ge    = ~rdiff[WIDTH];
    d_hi  = ge ? rdiff[WIDTH-1:0] : rsh[WIDTH-1:0];
    d_lo  = {lo_q[WIDTH-2:0], ge};
    quo   = neg_q ? -d_lo : d_lo;
  end

  // Datapath: latch operands on start, iterate, write result on DONE entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_q <= '0; lo_q <= '0; m_q <= '0; q1_q <= 1'b0;
      neg_q <= 1'b0; dz_q <= 1'b0; ovf_q <= 1'b0;
      data_result <= '0; data_exception <= 1'b0;
    end else if (start) begin
      hi_q <= '0;
      q1_q <= 1'b0;
      if (ctrl_MULT) begin
        lo_q  <= data_operandB;
        m_q   <= data_operandA;
        neg_q <= 1'b0; dz_q <= 1'b0; ovf_q <= 1'b0;
      end else begin
        lo_q  <= abs_a;
        m_q   <= abs_b;
        neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz_q  <= (data_operandB == '0);
        ovf_q <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
      end
      if (early_dz) begin
        data_result    <= '0;
        data_exception <= 1'b1;
      end
    end else begin
      case (state_q)
        MUL: begin
          hi_q <= b_hi; lo_q <= b_lo; q1_q <= lo_q[0];
          if (last) begin
            data_result    <= product[WIDTH-1:0];
            data_exception <= mul_exc;
          end
        end
        DIV: begin
          hi_q <= d_hi; lo_q <= d_lo;
          if (last) begin
            if (dz_q) begin
              data_result <= '0; data_exception <= 1'b1;
            end else if (ovf_q) begin
              data_result <= {1'b1, {(WIDTH-1){1'b0}}}; data_exception <= 1'b1;
            end else begin
              data_result <= quo; data_exception <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: expectations queued at issue, checked on RDY.
module tb_multdiv_seq;
  logic        clock, reset, ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic        data_exception, data_resultRDY, busy;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

`ifdef MULTDIV_EARLY_EXC_EN
  localparam int LAT_DZ = 1;
`else
  localparam int LAT_DZ = 33;
`endif

  multdiv_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void mul_model(input logic [31:0] a, b, output logic [31:0] r, output logic e);
    longint p;
    logic [63:0] pv;
    p  = longint'($signed(a)) * longint'($signed(b));
    pv = p;
    r  = pv[31:0];
    e  = !((pv[63:31] == '0) || (pv[63:31] == '1));
  endfunction

  function automatic void div_model(input logic [31:0] a, b, output logic [31:0] r, output logic e);
    int q;
    if (b == 32'd0) begin
      r = 32'd0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q; e = 1'b0;
    end
  endfunction

  // Drive a one-cycle start; the cycle it is sampled in is cycle 0.
  task automatic issue(input logic mul, input logic div, input logic [31:0] a, b,
                       input logic push, input logic [31:0] er, input logic ee, input int lat);
    @(negedge clock);
    ctrl_MULT = mul; ctrl_DIV = div;
    data_operandA = a; data_operandB = b;
    if (push) sb.push_back('{er, ee, cyc + lat});
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  // Result monitor: every RDY must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (data_resultRDY) begin
      if (sb.size() == 0) check("unexpected_rdy", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check("result", data_result, e.res);
        check("exception", {31'b0, data_exception}, {31'b0, e.exc});
        check("rdy_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    logic [31:0] a, b, r;
    logic        e, m;
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (3) @(negedge clock);
    check("rst_result", data_result, 32'd0);
    check("rst_exc", {31'b0, data_exception}, 32'd0);
    check("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;

    issue(1, 0, 32'd7, -32'd3, 1, 32'hFFFF_FFEB, 1'b0, 33);
    wait_done();
    issue(1, 0, 32'h0001_0000, 32'h0001_0000, 1, 32'd0, 1'b1, 33);
    wait_done();

    // busy must be high for exactly cycles 1..32
    issue(0, 1, -32'd7, 32'd2, 1, 32'hFFFF_FFFD, 1'b0, 33);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clock);
      check($sformatf("busy_c%0d", k), {31'b0, busy}, (k <= 32) ? 32'd1 : 32'd0);
    end
    wait_done();

    issue(0, 1, 32'd5, 32'd0, 1, 32'd0, 1'b1, LAT_DZ);
    wait_done();

    // Restart mid-op: only the second op reports
    issue(1, 0, 32'd3, 32'd4, 0, '0, 1'b0, 0);
    repeat (9) @(negedge clock);
    issue(0, 1, 32'd100, 32'd7, 1, 32'd14, 1'b0, 33);
    wait_done();

    // Reset mid-op aborts with no RDY
    issue(1, 0, 32'd9, 32'd9, 0, '0, 1'b0, 0);
    repeat (14) @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_result", data_result, 32'd0);
    check("abort_exc", {31'b0, data_exception}, 32'd0);
    repeat (40) @(negedge clock);
    issue(1, 0, 32'd9, 32'd9, 1, 32'd81, 1'b0, 33);
    wait_done();

    // Corner cases: MIN/-1, MIN*-1, both ctrls high (multiply wins)
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b1, 33);
    wait_done();
    issue(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b1, 33);
    wait_done();
    issue(1, 1, 32'd6, 32'd0, 1, 32'd0, 1'b0, 33);
    wait_done();
    issue(0, 1, -32'd100, -32'd7, 1, 32'd14, 1'b0, 33);
    wait_done();

    // Random mix against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? ($urandom_range(0, 40) - 20) : $urandom;
      if (i % 4 == 1) a = $urandom_range(0, 2000) - 1000;
      m = (i % 2 == 0);
      if (m) mul_model(a, b, r, e);
      else   div_model(a, b, r, e);
      issue(m, !m, a, b, 1, r, e, (!m && b == 32'd0) ? LAT_DZ : 33);
      wait_done();
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
